// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and size codes for the byte-wide memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_TAIL,
    ST_WR,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Index of the last byte lane for a size code; code 3 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 2'd0;
      MEM_HALF: return 2'd1;
      MEM_WORD: return 2'd3;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between IF and LS with an LS-streak starvation counter.
module mem_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic if_req,
  input  logic ls_req,
  output logic grant_if,
  output logic grant_ls
);

  localparam int unsigned        CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]      LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve;

  // LS wins unless IF has been passed over LIMIT times in a row.
  always_comb begin
    grant_ls = sample && ls_req && (!if_req || (starve < LIMIT));
    grant_if = sample && if_req && !grant_ls;
  end

  // Count LS grants taken while IF waits; any IF grant or idle IF clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (sample) begin
      if (!if_req || grant_if) begin
        starve <= '0;
      end else if (grant_ls && (starve != LIMIT)) begin
        starve <= starve + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Byte-serial RAM port shared by instruction fetch and load/store.
// Reads assemble little-endian words; writes emit one byte per cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  arb_state_e        state, state_nxt;
  owner_e            owner;
  logic [ADDR_W-1:0] xaddr;
  logic [1:0]        xlast, idx, idx_nxt, idx_prev;
  logic [31:0]       xwdata, rbuf, rword;
  logic              sample, grant_if, grant_ls;

  assign sample   = (state == ST_IDLE);
  assign idx_nxt  = idx + 2'd1;
  assign idx_prev = idx - 2'd1;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .sample   (sample),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-owner done pulse.
  always_comb begin
    state_nxt = state;
    if_done   = 1'b0;
    ls_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_ls)      state_nxt = ls_we ? ST_WR : ST_RD;
        else if (grant_if) state_nxt = ST_RD;
      end
      ST_RD:      if (idx == xlast) state_nxt = ST_RD_TAIL;
      ST_RD_TAIL: state_nxt = ST_DONE;
      ST_WR:      if (idx == xlast) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if_done   = (owner == OWN_IF);
        ls_done   = (owner == OWN_LS);
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Final read word: buffered lanes plus the lane arriving in RD_TAIL.
  always_comb begin
    rword = rbuf;
    rword[{xlast, 3'b000} +: 8] = ram_din;
  end

  // Transfer latch, address/data sequencing and read assembly.
  // ram_din lags ram_addr by one cycle, so RD cycle k captures lane k-1
  // and RD_TAIL captures the last lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= OWN_IF;
      xaddr    <= '0;
      xlast    <= '0;
      xwdata   <= '0;
      idx      <= '0;
      rbuf     <= '0;
      ram_addr <= '0;
      ram_wr   <= 1'b0;
      ram_dout <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx  <= '0;
          rbuf <= '0;
          if (grant_ls) begin
            owner    <= OWN_LS;
            xaddr    <= ls_addr;
            xlast    <= size_last(ls_size);
            xwdata   <= ls_wdata;
            ram_addr <= ls_addr;
            ram_wr   <= ls_we;
            if (ls_we) ram_dout <= ls_wdata[7:0];
          end else if (grant_if) begin
            owner    <= OWN_IF;
            xaddr    <= if_addr;
            xlast    <= 2'd3;
            ram_addr <= if_addr;
            ram_wr   <= 1'b0;
          end
        end
        ST_RD: begin
          if (idx != 2'd0) rbuf[{idx_prev, 3'b000} +: 8] <= ram_din;
          if (idx != xlast) begin
            idx      <= idx_nxt;
            ram_addr <= xaddr + ADDR_W'(idx_nxt);
          end
        end
        ST_RD_TAIL: begin
          if (owner == OWN_IF) if_rdata <= rword;
          else                 ls_rdata <= rword;
        end
        ST_WR: begin
          if (idx != xlast) begin
            idx      <= idx_nxt;
            ram_addr <= xaddr + ADDR_W'(idx_nxt);
            ram_dout <= xwdata[{idx_nxt, 3'b000} +: 8];
          end else begin
            ram_wr   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the shared byte-wide memory port.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, ram_addr;
  logic [1:0]    ls_size;
  logic [31:0]   ls_wdata, if_rdata, ls_rdata;
  logic          if_done, ls_done, ram_wr;
  logic [7:0]    ram_dout, ram_din;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  // RAM: 64 KiB window on the low address bits, one-cycle read latency.
  logic [7:0]  ram   [0:65535];
  bit          ram_v [0:65535];
  logic [39:0] wr_log [$];

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    ram_din <= ram_v[ram_addr[15:0]] ? ram[ram_addr[15:0]] : dflt(ram_addr[15:0]);
    if (ram_wr) begin
      ram[ram_addr[15:0]]   <= ram_dout;
      ram_v[ram_addr[15:0]] <= 1'b1;
      wr_log.push_back({ram_addr, ram_dout});
    end
  end

  // Reference memory keyed by the full byte address.
  logic [7:0]  ref_mem [logic [31:0]];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;
  bit          last_ls_known = 1'b1;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a[15:0]);
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int unsigned n);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " if_rdata"}, if_rdata, 0);
    check({tag, " ls_rdata"}, ls_rdata, 0);
    check({tag, " if_done"},  if_done,  0);
    check({tag, " ls_done"},  ls_done,  0);
    check({tag, " ram_addr"}, ram_addr, 0);
    check({tag, " ram_wr"},   ram_wr,   0);
    check({tag, " ram_dout"}, ram_dout, 0);
  endtask

  task automatic wait_done(output bit gi, output bit gl, output int unsigned cyc);
    cyc = 0; gi = 0; gl = 0;
    while (!(gi || gl) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      gi = if_done;
      gl = ls_done;
    end
  endtask

  // One transfer from an idle port by a single requester.
  task automatic do_xfer(input bit is_ls, input bit we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
    int unsigned n, cyc;
    bit          got, wrong;
    logic [31:0] exp_rd;
    logic [39:0] ent;
    n      = is_ls ? nbytes(sz) : 4;
    exp_rd = ref_word(addr, n);
    wr_log.delete();
    if (is_ls) begin
      ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    cyc = 0; got = 0; wrong = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      got = is_ls ? ls_done : if_done;
      if (is_ls ? if_done : ls_done) wrong = 1;
      if (cyc == 1) begin
        // Request fields change after the grant and must be ignored.
        ls_addr = $urandom; ls_wdata = $urandom; ls_size = 2'($urandom);
        ls_we = 1'($urandom); if_addr = $urandom;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check($sformatf("%s latency", tag), cyc, we ? n + 1 : n + 2);
    check($sformatf("%s other done", tag), wrong, 0);
    if (!we) begin
      check($sformatf("%s write count", tag), wr_log.size(), 0);
      if (is_ls) begin
        check($sformatf("%s ls_rdata", tag), ls_rdata, exp_rd);
        last_ls = exp_rd; last_ls_known = 1'b1;
        check($sformatf("%s if_rdata held", tag), if_rdata, last_if);
      end else begin
        check($sformatf("%s if_rdata", tag), if_rdata, exp_rd);
        last_if = exp_rd;
        if (last_ls_known) check($sformatf("%s ls_rdata held", tag), ls_rdata, last_ls);
      end
    end else begin
      check($sformatf("%s write count", tag), wr_log.size(), n);
      for (int unsigned k = 0; k < n; k++) begin
        ent = {addr + k, wdata[8*k +: 8]};
        if (k < wr_log.size()) check($sformatf("%s write %0d", tag, k), wr_log[k], ent);
        ref_mem[addr + k] = wdata[8*k +: 8];
      end
      last_ls_known = 1'b0;
      check($sformatf("%s if_rdata held", tag), if_rdata, last_if);
    end
    @(posedge clk); #1;
    check($sformatf("%s done pulse", tag), {if_done, ls_done}, 0);
  endtask

  initial begin
    bit          gi, gl;
    int unsigned cyc, dones;
    rst = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; ls_size = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed transfers.
    do_xfer(1, 1, 2'd2, 32'h0000_0100, 32'h4433_2211, "st_w_100");
    do_xfer(0, 0, 2'd2, 32'h0000_0100, 32'h0,         "if_100");
    check("if_100 value", if_rdata, 32'h4433_2211);
    do_xfer(1, 1, 2'd2, 32'h0000_7FFE, 32'hDEAD_BEEF, "st_w_7ffe");
    do_xfer(1, 1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00AA, "st_b_top");
    do_xfer(1, 1, 2'd0, 32'h0000_0000, 32'h0000_0055, "st_b_zero");
    do_xfer(1, 0, 2'd1, 32'hFFFF_FFFF, 32'h0,         "ld_h_wrap");
    check("ld_h_wrap value", ls_rdata, 32'h0000_55AA);
    do_xfer(1, 0, 2'd2, 32'h0000_7FFE, 32'h0,         "ld_w_7ffe");
    check("ld_w_7ffe value", ls_rdata, 32'hDEAD_BEEF);

    // Reset during the third read cycle of an IF word fetch.
    if_addr = 32'h0000_0100; if_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; if_req = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if_done || ls_done) dones++;
    end
    check("post_reset no done", dones, 0);
    last_if = '0; last_ls = '0; last_ls_known = 1'b1;

    // Simultaneous requests with an empty starve count: LS first, then IF.
    if_addr = 32'h0000_0100; ls_addr = 32'h0000_7FFE; ls_we = 0; ls_size = 2'd2;
    if_req = 1'b1; ls_req = 1'b1;
    wait_done(gi, gl, cyc);
    check("same_edge first owner", {gi, gl}, 2'b01);
    check("same_edge ls_rdata", ls_rdata, ref_word(32'h0000_7FFE, 4));
    ls_req = 1'b0;
    wait_done(gi, gl, cyc);
    check("same_edge second owner", {gi, gl}, 2'b10);
    check("same_edge if gap", cyc, 7);
    check("same_edge if_rdata", if_rdata, ref_word(32'h0000_0100, 4));
    if_req = 1'b0;
    @(posedge clk); #1;

    // Both requests held: IF gets every (SL+1)-th grant.
    if_addr = 32'h0000_0100; ls_addr = 32'h0000_7FFF; ls_we = 0; ls_size = 2'd0;
    if_req = 1'b1; ls_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_done(gi, gl, cyc);
      check($sformatf("hold grant %0d", i), {gi, gl}, ((i % (SL + 1)) == SL) ? 2'b10 : 2'b01);
      if (gl) check($sformatf("hold ls_rdata %0d", i), ls_rdata, ref_word(32'h0000_7FFF, 1));
      if (gi) check($sformatf("hold if_rdata %0d", i), if_rdata, ref_word(32'h0000_0100, 4));
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk); #1;
    last_if = ref_word(32'h0000_0100, 4);
    last_ls = ref_word(32'h0000_7FFF, 1);

    // Random single-requester traffic.
    for (int i = 0; i < 24; i++) begin
      bit          r_ls, r_we;
      logic [1:0]  r_sz;
      logic [31:0] r_a, r_d;
      r_ls = ($urandom_range(0, 2) != 0);
      r_we = r_ls && ($urandom_range(0, 1) == 1);
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom_range(0, 32'h3FFF);
      r_d  = $urandom;
      do_xfer(r_ls, r_we, r_sz, r_a, r_d, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
